rom_fetch_arbiter: RTL

- Shares one synchronous-read, byte-wide ROM (registered read, 1-cycle latency) between two requesters: port 0 (instruction fetch) and port 1 (data load / VGA reader).
- Each granted request reads WORD_BYTES consecutive ROM bytes and returns them as one little-endian word.
- Two-requester round-robin arbitration; one word in flight at a time.
- Sits between the core's fetch/load units and the ROM instance.

---
 rtl/rom_fetch_arbiter_if.sv | 44 ++++
 rtl/rom_fetch_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rom_fetch_arbiter_if.sv
// Requester-side bundle for the shared ROM fetch arbiter.
// Two word-fetch ports plus the arbiter busy flag.
interface rom_fetch_arbiter_if #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int WORD_BYTES    = 4
);

  logic                       p0_req;
  logic [ADDRESS_WIDTH-1:0]   p0_addr;
  logic                       p0_done;
  logic [8*WORD_BYTES-1:0]    p0_rdata;

  logic                       p1_req;
  logic [ADDRESS_WIDTH-1:0]   p1_addr;
  logic                       p1_done;
  logic [8*WORD_BYTES-1:0]    p1_rdata;

  logic                       busy;

  modport master (
    output p0_req,
    output p0_addr,
    input  p0_done,
    input  p0_rdata,
    output p1_req,
    output p1_addr,
    input  p1_done,
    input  p1_rdata,
    input  busy
  );

  modport slave (
    input  p0_req,
    input  p0_addr,
    output p0_done,
    output p0_rdata,
    input  p1_req,
    input  p1_addr,
    output p1_done,
    output p1_rdata,
    output busy
  );

endinterface

// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing a byte-wide registered ROM between two
// word fetchers; assembles WORD_BYTES bytes little-endian per grant.
module rom_fetch_arbiter #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int WORD_BYTES    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rom_fetch_arbiter_if.slave       bus,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [7:0]               rom_data
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int WW = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            owner;
  logic            last_grant;
  logic [AW-1:0]   base;
  logic [AW-1:0]   addr_q;
  logic [WW-1:0]   word_q;
  logic            busy_q;
  logic            p0_done_q;
  logic            p1_done_q;
  logic [WW-1:0]   p0_rdata_q;
  logic [WW-1:0]   p1_rdata_q;

  logic            gnt_any;
  logic            gnt_sel;
  logic [AW-1:0]   gnt_addr;
  logic [AW-1:0]   next_addr;

  assign rom_addr     = addr_q;
  assign bus.busy     = busy_q;
  assign bus.p0_done  = p0_done_q;
  assign bus.p1_done  = p1_done_q;
  assign bus.p0_rdata = p0_rdata_q;
  assign bus.p1_rdata = p1_rdata_q;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    gnt_any = bus.p0_req | bus.p1_req;
    gnt_sel = 1'b0;
    unique case (1'b1)
      bus.p0_req & bus.p1_req:  gnt_sel = ~last_grant;
      bus.p0_req & ~bus.p1_req: gnt_sel = 1'b0;
      ~bus.p0_req & bus.p1_req: gnt_sel = 1'b1;
      default:                  gnt_sel = 1'b0;
    endcase
    gnt_addr = gnt_sel ? bus.p1_addr : bus.p0_addr;
  end

  // Wraps naturally at 2^AW.
  assign next_addr = base + AW'(cnt) + AW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      base       <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      p0_done_q <= 1'b0;
      p1_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            owner      <= gnt_sel;
            last_grant <= gnt_sel;
            base       <= gnt_addr;
            addr_q     <= gnt_addr;
            cnt        <= '0;
            busy_q     <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (cnt < CW'(WORD_BYTES - 1)) begin
            addr_q <= next_addr;
          end
          // ROM data lags the issued address by one edge.
          for (int i = 0; i < WORD_BYTES; i++) begin
            if (cnt == CW'(i + 1)) begin
              word_q[8*i +: 8] <= rom_data;
            end
          end
          if (cnt == CW'(WORD_BYTES)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (owner) begin
            p1_rdata_q <= word_q;
            p1_done_q  <= 1'b1;
          end else begin
            p0_rdata_q <= word_q;
            p0_done_q  <= 1'b1;
          end
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
